mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline; the consumer of the EX/MEM pipeline register. It takes the latched control and data fields from EX/MEM and performs loads and stores through a req/ack data-memory port, stalling upstream while the memory is busy. It resolves the branch decision and drives the registered MEM/WB fields consumed by write-back.

## Interface
- DATA_W, 32, width of ALU result, store data, load data and dst
- PC_W, 7, width of the branch target
- ADDR_W, 8, data-memory word-address width
- TIMEOUT, 15, max WAIT cycles before abandoning an access (>=1)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mem_to_reg_reg, reg_write_reg, branch_reg, mem_write_reg, mem_read_reg, zero_reg  in  1 each  latched EX/MEM controls
- pc_branch_reg  in  PC_W  latched branch target
- alu_result_reg, data2_reg, dst_reg  in  DATA_W each  latched address/result, store data, destination
- mem_req  out  1  access request to data memory
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  ADDR_W  alu_result_reg[ADDR_W+1:2]
- mem_wdata  out  DATA_W  data2_reg
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle on reads
- mem_rdata  in  DATA_W  read data
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- pc_src  out  1  take branch
- pc_target  out  PC_W  pc_branch_reg passthrough
- mem_to_reg_wb, reg_write_wb  out  1 each  registered MEM/WB controls
- read_data_wb, alu_result_wb, dst_wb  out  DATA_W each  registered MEM/WB data
- err  out  1  sticky timeout flag

## Operation
- Access = mem_read_reg | mem_write_reg. If both are set, the access is treated as a write and read_data_wb loads 0.
- FSM states: IDLE, WAIT.
- IDLE, no access: mem_req=0, stall=0; MEM/WB loads the EX/MEM fields, read_data_wb=0.
- IDLE, access: mem_req=1 combinationally, mem_we=mem_write_reg.
  - mem_ack=1 in the same cycle: zero-wait completion, stall=0, MEM/WB loads with read_data_wb=mem_rdata (reads), stay in IDLE.
  - Otherwise: stall=1, MEM/WB loads a bubble, go to WAIT, wait counter=1.
- WAIT: mem_req=1; mem_addr, mem_we and mem_wdata stay stable because EX/MEM is frozen by stall.
  - mem_ack=1: stall=0 that cycle, MEM/WB loads the instruction (with mem_rdata on reads), go to IDLE.
  - No ack and counter==TIMEOUT: set err, drop mem_req next cycle, stall=0 that cycle, MEM/WB loads a bubble, go to IDLE.
  - Otherwise: stall=1, counter increments, MEM/WB loads a bubble.
- Bubble = reg_write_wb=0, mem_to_reg_wb=0; data fields hold their previous values.
- pc_src = branch_reg & zero_reg & ~stall, combinational; pc_target = pc_branch_reg.
- mem_ack while mem_req=0 is ignored.
- err is cleared only by reset.

## Timing
- Reset values: all *_wb outputs 0, err 0, FSM in IDLE, counter 0; consequently mem_req=0 and stall=0.
- Reset asserted mid-WAIT: immediate return to IDLE, mem_req drops asynchronously, the access is lost.
- Latency EX/MEM to MEM/WB: 1 cycle for non-memory ops and zero-wait accesses; 1+N cycles for an access acked after N WAIT cycles.
- stall is high for exactly the cycles where mem_req=1 and mem_ack=0, except the timeout cycle.
- Counter width is clog2(TIMEOUT+1); it never wraps.
- Back-to-back accesses: after an ack the next access may request in the following cycle; there are no idle gap cycles.

## Structure
- Package mem_stage_pkg holds the state enum (IDLE, WAIT) and the bubble constant values.
- One natural sub-module, mem_wb_reg: the MEM/WB register with a load/bubble select and asynchronous reset.
- The FSM, counter and combinational port logic live in mem_stage.

## Test plan
- Reset, then hold: all outputs 0. Assert reset mid-WAIT: mem_req and stall drop at once, state returns to IDLE.
- Non-memory op (alu_result_reg=0x2A, dst_reg=5, reg_write_reg=1) -> next edge alu_result_wb=0x2A, dst_wb=5, reg_write_wb=1, stall never high.
- Load at alu_result_reg=0x10 with mem_ack tied high -> mem_addr=4, no stall, read_data_wb=mem_rdata (0xDEADBEEF) after 1 edge.
- Store data2_reg=0x55, ack after 3 cycles -> stall high for 3 cycles, mem_we=1, mem_wdata=0x55 stable throughout, reg_write_wb=0 during the stall cycles.
- Access with no ack, TIMEOUT=15 -> stall high for 15 cycles, then err=1 and mem_req=0; err stays 1 until reset.
- branch_reg=1, zero_reg=1, pc_branch_reg=0x3C -> pc_src=1, pc_target=0x3C; with zero_reg=0 -> pc_src=0; read+write both set -> mem_we=1, read_data_wb=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // Control values written into MEM/WB when no instruction retires this cycle
   localparam logic BUBBLE_REG_WRITE  = 1'b0;
   localparam logic BUBBLE_MEM_TO_REG = 1'b0;

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register: loads a retiring instruction or inserts a bubble.
// A bubble clears only the controls; data fields keep their previous values.
module mem_wb_reg
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              mem_to_reg,
   input  logic              reg_write,
   input  logic [DATA_W-1:0] read_data,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] dst,
   output logic              mem_to_reg_wb,
   output logic              reg_write_wb,
   output logic [DATA_W-1:0] read_data_wb,
   output logic [DATA_W-1:0] alu_result_wb,
   output logic [DATA_W-1:0] dst_wb
);

   // Retire the instruction on load, otherwise turn the controls into a bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_to_reg_wb <= 1'b0;
         reg_write_wb  <= 1'b0;
         read_data_wb  <= '0;
         alu_result_wb <= '0;
         dst_wb        <= '0;
      end else if (load) begin
         mem_to_reg_wb <= mem_to_reg;
         reg_write_wb  <= reg_write;
         read_data_wb  <= read_data;
         alu_result_wb <= alu_result;
         dst_wb        <= dst;
      end else begin
         mem_to_reg_wb <= BUBBLE_MEM_TO_REG;
         reg_write_wb  <= BUBBLE_REG_WRITE;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the req/ack data-memory port from the EX/MEM
// fields, stalls upstream while an access is outstanding, abandons an access
// after TIMEOUT wait cycles, resolves branches and feeds the MEM/WB register.
//
// state | meaning
// IDLE  | no access outstanding; a new access requests combinationally
// WAIT  | access requested but not yet acked; EX/MEM held by stall
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int PC_W    = 7,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_to_reg_reg,
   input  logic              reg_write_reg,
   input  logic              branch_reg,
   input  logic              mem_write_reg,
   input  logic              mem_read_reg,
   input  logic              zero_reg,
   input  logic [PC_W-1:0]   pc_branch_reg,
   input  logic [DATA_W-1:0] alu_result_reg,
   input  logic [DATA_W-1:0] data2_reg,
   input  logic [DATA_W-1:0] dst_reg,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic              pc_src,
   output logic [PC_W-1:0]   pc_target,
   output logic              mem_to_reg_wb,
   output logic              reg_write_wb,
   output logic [DATA_W-1:0] read_data_wb,
   output logic [DATA_W-1:0] alu_result_wb,
   output logic [DATA_W-1:0] dst_wb,
   output logic              err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_t            state;
   logic [CNT_W-1:0]  wait_cnt;
   logic              access;
   logic              timeout_hit;
   logic              wb_load;
   logic [DATA_W-1:0] wb_read_data;

   // Port logic; reset gates the request so it drops asynchronously mid-WAIT
   always_comb begin
      access       = mem_read_reg | mem_write_reg;
      mem_req      = ~reset & ((state == IDLE && access) || state == WAIT);
      mem_we       = mem_write_reg;
      mem_addr     = alu_result_reg[ADDR_W+1:2];
      mem_wdata    = data2_reg;
      timeout_hit  = (state == WAIT) && !mem_ack && (wait_cnt == CNT_MAX);
      stall        = mem_req & ~mem_ack & ~timeout_hit;
      wb_load      = ~stall & ~timeout_hit;
      pc_src       = branch_reg & zero_reg & ~stall;
      pc_target    = pc_branch_reg;
      // A read+write pair counts as a write, so nothing is loaded from memory
      wb_read_data = '0;
      if (mem_req && mem_ack && mem_read_reg && !mem_write_reg)
         wb_read_data = mem_rdata;
   end

   // Access FSM with saturating wait counter and sticky timeout flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_req && !mem_ack) begin
                  state    <= WAIT;
                  wait_cnt <= CNT_W'(1);
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  state    <= IDLE;
                  wait_cnt <= '0;
               end else if (timeout_hit) begin
                  state    <= IDLE;
                  wait_cnt <= '0;
                  err      <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb_reg (
      .clk           (clk),
      .reset         (reset),
      .load          (wb_load),
      .mem_to_reg    (mem_to_reg_reg),
      .reg_write     (reg_write_reg),
      .read_data     (wb_read_data),
      .alu_result    (alu_result_reg),
      .dst           (dst_reg),
      .mem_to_reg_wb (mem_to_reg_wb),
      .reg_write_wb  (reg_write_wb),
      .read_data_wb  (read_data_wb),
      .alu_result_wb (alu_result_wb),
      .dst_wb        (dst_wb)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written multi-cycle
// sequences, then random instructions checked against a transaction model.
module tb_mem_stage;

   localparam int DATA_W  = 32;
   localparam int PC_W    = 7;
   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 15;

   logic              clk;
   logic              reset;
   logic              mem_to_reg_reg, reg_write_reg, branch_reg;
   logic              mem_write_reg, mem_read_reg, zero_reg;
   logic [PC_W-1:0]   pc_branch_reg;
   logic [DATA_W-1:0] alu_result_reg, data2_reg, dst_reg;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall, pc_src;
   logic [PC_W-1:0]   pc_target;
   logic              mem_to_reg_wb, reg_write_wb;
   logic [DATA_W-1:0] read_data_wb, alu_result_wb, dst_wb;
   logic              err;

   int n_checks = 0;
   int n_pass   = 0;

   mem_stage #(
      .DATA_W(DATA_W), .PC_W(PC_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .mem_to_reg_reg(mem_to_reg_reg), .reg_write_reg(reg_write_reg),
      .branch_reg(branch_reg), .mem_write_reg(mem_write_reg),
      .mem_read_reg(mem_read_reg), .zero_reg(zero_reg),
      .pc_branch_reg(pc_branch_reg), .alu_result_reg(alu_result_reg),
      .data2_reg(data2_reg), .dst_reg(dst_reg),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
      .mem_to_reg_wb(mem_to_reg_wb), .reg_write_wb(reg_write_wb),
      .read_data_wb(read_data_wb), .alu_result_wb(alu_result_wb),
      .dst_wb(dst_wb), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic clear_inputs();
      mem_to_reg_reg = 1'b0; reg_write_reg = 1'b0; branch_reg = 1'b0;
      mem_write_reg  = 1'b0; mem_read_reg  = 1'b0; zero_reg   = 1'b0;
      pc_branch_reg  = '0;   alu_result_reg = '0;  data2_reg  = '0;
      dst_reg        = '0;   mem_ack        = 1'b0; mem_rdata = '0;
   endtask

   typedef struct {
      logic rd, wr, mtr, rw, br, zr, ack;
      logic [PC_W-1:0]   pcb;
      logic [DATA_W-1:0] alu, d2, dst, rdata;
      logic e_req, e_we, e_stall, e_pcsrc;
      logic [ADDR_W-1:0] e_addr;
      logic e_rw, e_mtr;
      logic [DATA_W-1:0] e_rd, e_alu, e_dst;
   } vec_t;

   vec_t vecs[8];

   // transaction-level model of the MEM/WB outputs and error flag
   logic              m_rw, m_mtr, m_err;
   logic [DATA_W-1:0] m_rd, m_alu, m_dst;

   initial begin
      int stall_cnt;
      logic [1:0] kind;
      int n_wait;
      logic rd_i, wr_i, acc, done, timed_out, exp_stall;
      logic [DATA_W-1:0] rdata_now;

      vecs[0] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 7'h00, 32'h2A, 32'h0, 32'd5, 32'h0,
                  1'b0,1'b0,1'b0,1'b0, 8'h0A, 1'b1,1'b0, 32'h0, 32'h2A, 32'd5};
      vecs[1] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 7'h00, 32'h10, 32'h0, 32'd7, 32'hDEADBEEF,
                  1'b1,1'b0,1'b0,1'b0, 8'h04, 1'b1,1'b1, 32'hDEADBEEF, 32'h10, 32'd7};
      vecs[2] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 7'h3C, 32'h100, 32'h0, 32'd0, 32'h0,
                  1'b0,1'b0,1'b0,1'b1, 8'h40, 1'b0,1'b0, 32'h0, 32'h100, 32'd0};
      vecs[3] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 7'h3C, 32'h104, 32'h0, 32'd0, 32'h0,
                  1'b0,1'b0,1'b0,1'b0, 8'h41, 1'b0,1'b0, 32'h0, 32'h104, 32'd0};
      vecs[4] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 7'h11, 32'h3FC, 32'h55, 32'd9, 32'h12345678,
                  1'b1,1'b1,1'b0,1'b0, 8'hFF, 1'b1,1'b1, 32'h0, 32'h3FC, 32'd9};
      vecs[5] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 7'h22, 32'h404, 32'hA5, 32'd3, 32'hCAFEF00D,
                  1'b1,1'b1,1'b0,1'b0, 8'h01, 1'b0,1'b0, 32'h0, 32'h404, 32'd3};
      vecs[6] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 7'h7F, 32'hFFFFFFF8, 32'h0, 32'd31, 32'h13579BDF,
                  1'b0,1'b0,1'b0,1'b0, 8'hFE, 1'b1,1'b1, 32'h0, 32'hFFFFFFF8, 32'd31};
      vecs[7] = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 7'h05, 32'h20, 32'h0, 32'd12, 32'h0BADF00D,
                  1'b1,1'b0,1'b0,1'b1, 8'h08, 1'b1,1'b1, 32'h0BADF00D, 32'h20, 32'd12};

      // ---- reset state
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_reg_write_wb", reg_write_wb, 1'b0);
      check("rst_mem_to_reg_wb", mem_to_reg_wb, 1'b0);
      check("rst_read_data_wb", read_data_wb, 32'h0);
      check("rst_alu_result_wb", alu_result_wb, 32'h0);
      check("rst_dst_wb", dst_wb, 32'h0);
      check("rst_err", err, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // ---- single-cycle vector table
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         mem_read_reg = vecs[i].rd;  mem_write_reg = vecs[i].wr;
         mem_to_reg_reg = vecs[i].mtr; reg_write_reg = vecs[i].rw;
         branch_reg = vecs[i].br;    zero_reg = vecs[i].zr;
         mem_ack = vecs[i].ack;      pc_branch_reg = vecs[i].pcb;
         alu_result_reg = vecs[i].alu; data2_reg = vecs[i].d2;
         dst_reg = vecs[i].dst;      mem_rdata = vecs[i].rdata;
         #1;
         check($sformatf("v%0d_mem_req", i), mem_req, vecs[i].e_req);
         if (vecs[i].e_req) begin
            check($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_we);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].d2);
         end
         check($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
         check($sformatf("v%0d_pc_src", i), pc_src, vecs[i].e_pcsrc);
         check($sformatf("v%0d_pc_target", i), pc_target, vecs[i].pcb);
         check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
         @(posedge clk); #1;
         check($sformatf("v%0d_reg_write_wb", i), reg_write_wb, vecs[i].e_rw);
         check($sformatf("v%0d_mem_to_reg_wb", i), mem_to_reg_wb, vecs[i].e_mtr);
         check($sformatf("v%0d_read_data_wb", i), read_data_wb, vecs[i].e_rd);
         check($sformatf("v%0d_alu_result_wb", i), alu_result_wb, vecs[i].e_alu);
         check($sformatf("v%0d_dst_wb", i), dst_wb, vecs[i].e_dst);
      end

      // ---- store acked after 3 wait cycles
      @(negedge clk);
      clear_inputs();
      mem_write_reg = 1'b1; reg_write_reg = 1'b1; data2_reg = 32'h55;
      alu_result_reg = 32'h80; dst_reg = 32'd4;
      stall_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         mem_ack = (c == 3);
         #1;
         if (stall) stall_cnt++;
         check("st_mem_req", mem_req, 1'b1);
         check("st_mem_we", mem_we, 1'b1);
         check("st_mem_wdata", mem_wdata, 32'h55);
         check("st_mem_addr", mem_addr, 8'h20);
         @(posedge clk); #1;
         check("st_reg_write_wb", reg_write_wb, (c == 3));
      end
      check("st_stall_cycles", stall_cnt, 3);
      check("st_alu_result_wb", alu_result_wb, 32'h80);

      // ---- access never acked: timeout
      @(negedge clk);
      clear_inputs();
      mem_read_reg = 1'b1; reg_write_reg = 1'b1; alu_result_reg = 32'h44;
      stall_cnt = 0;
      for (int c = 0; c <= TIMEOUT; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (stall) stall_cnt++;
         if (c == TIMEOUT) begin
            check("to_last_stall", stall, 1'b0);
            check("to_last_req", mem_req, 1'b1);
         end
         @(posedge clk); #1;
      end
      check("to_stall_cycles", stall_cnt, TIMEOUT);
      check("to_err_set", err, 1'b1);
      check("to_reg_write_wb_bubble", reg_write_wb, 1'b0);
      @(negedge clk);
      clear_inputs();
      #1;
      check("to_req_dropped", mem_req, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("to_err_sticky", err, 1'b1);

      // ---- reset asserted in the middle of WAIT
      @(negedge clk);
      mem_read_reg = 1'b1; reg_write_reg = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rw_stall_before", stall, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      check("rw_mem_req", mem_req, 1'b0);
      check("rw_stall", stall, 1'b0);
      check("rw_err", err, 1'b0);
      check("rw_reg_write_wb", reg_write_wb, 1'b0);
      @(negedge clk);
      clear_inputs();
      reset = 1'b0;
      // back in IDLE: a fresh access acked at once completes with no stall
      @(negedge clk);
      mem_read_reg = 1'b1; reg_write_reg = 1'b1; mem_ack = 1'b1;
      mem_rdata = 32'hA1B2C3D4; dst_reg = 32'd2;
      #1;
      check("rw_idle_nostall", stall, 1'b0);
      @(posedge clk); #1;
      check("rw_idle_read_data_wb", read_data_wb, 32'hA1B2C3D4);

      // ---- random instructions against the transaction model
      m_rw = 1'b1; m_mtr = 1'b0; m_err = 1'b0;
      m_rd = 32'hA1B2C3D4; m_alu = 32'h0; m_dst = 32'd2;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         kind = 2'($urandom_range(0, 3));
         rd_i = kind[0]; wr_i = kind[1];
         acc = rd_i | wr_i;
         mem_read_reg = rd_i; mem_write_reg = wr_i;
         mem_to_reg_reg = 1'($urandom_range(0, 1));
         reg_write_reg  = 1'($urandom_range(0, 1));
         branch_reg     = 1'($urandom_range(0, 1));
         zero_reg       = 1'($urandom_range(0, 1));
         pc_branch_reg  = PC_W'($urandom);
         alu_result_reg = $urandom; data2_reg = $urandom; dst_reg = $urandom;
         n_wait = $urandom_range(0, 9);
         if (n_wait < 4) n_wait = 0;
         else if (n_wait < 9) n_wait = $urandom_range(1, 5);
         else n_wait = $urandom_range(6, TIMEOUT + 2);
         for (int c = 0; c <= TIMEOUT; c++) begin
            if (c > 0) @(negedge clk);
            mem_ack   = acc ? (c == n_wait) : 1'($urandom_range(0, 1));
            rdata_now = $urandom;
            mem_rdata = rdata_now;
            exp_stall = acc && (c < n_wait) && (c < TIMEOUT);
            timed_out = acc && (n_wait > TIMEOUT) && (c == TIMEOUT);
            done      = !acc || (c == n_wait) || timed_out;
            #1;
            check("rnd_mem_req", mem_req, acc);
            check("rnd_stall", stall, exp_stall);
            check("rnd_pc_src", pc_src, branch_reg & zero_reg & ~exp_stall);
            check("rnd_pc_target", pc_target, pc_branch_reg);
            check("rnd_mem_addr", mem_addr, ADDR_W'(alu_result_reg >> 2));
            if (acc) begin
               check("rnd_mem_we", mem_we, wr_i);
               check("rnd_mem_wdata", mem_wdata, data2_reg);
            end
            @(posedge clk); #1;
            if (done && !timed_out) begin
               m_rw  = reg_write_reg; m_mtr = mem_to_reg_reg;
               m_alu = alu_result_reg; m_dst = dst_reg;
               m_rd  = (rd_i && !wr_i) ? rdata_now : '0;
            end else begin
               m_rw = 1'b0; m_mtr = 1'b0;
            end
            if (timed_out) m_err = 1'b1;
            check("rnd_reg_write_wb", reg_write_wb, m_rw);
            check("rnd_mem_to_reg_wb", mem_to_reg_wb, m_mtr);
            check("rnd_read_data_wb", read_data_wb, m_rd);
            check("rnd_alu_result_wb", alu_result_wb, m_alu);
            check("rnd_dst_wb", dst_wb, m_dst);
            check("rnd_err", err, m_err);
            if (done) break;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
